// File: rtl/demod_boxcar_decimator.sv
// Integrate-and-dump averager: sums 2^active_log2n valid samples, emits one rounded mean per frame.
// Latency 1 cycle from last sample to out_valid; no backpressure on data, cfg held off via cfg_ready while pending.
module demod_boxcar_decimator #(
    parameter int IN_W           = 32,
    parameter int LOG2_N_MAX     = 10,
    parameter int DEFAULT_LOG2_N = 4
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [IN_W-1:0]                    in_data,
    input  logic                               in_valid,
    input  logic                               clear,
    input  logic [$clog2(LOG2_N_MAX+1)-1:0]    cfg_log2_n,
    input  logic                               cfg_valid,
    output logic                               cfg_ready,
    output logic [IN_W-1:0]                    out_data,
    output logic                               out_valid,
    output logic [$clog2(LOG2_N_MAX+1)-1:0]    active_log2n
);

    localparam int LW    = $clog2(LOG2_N_MAX + 1);
    localparam int ACC_W = IN_W + LOG2_N_MAX;
    localparam int CNT_W = LOG2_N_MAX + 1;

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic [IN_W-1:0]         out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic [LW-1:0]           active_q, active_d;
    logic                    pending_q, pending_d;
    logic [LW-1:0]           pend_val_q, pend_val_d;

    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] acc_sum;
    logic signed [ACC_W:0]   rnd_bias;
    logic signed [ACC_W:0]   rnd_sum;
    logic [CNT_W-1:0]        last_cnt;
    logic [LW-1:0]           cfg_clamped;
    logic                    frame_end;
    logic                    boundary;
    logic                    cfg_accept;

    always_comb begin
        sample_ext  = $signed({{LOG2_N_MAX{in_data[IN_W-1]}}, in_data});
        acc_sum     = acc_q + sample_ext;
        last_cnt    = (CNT_W'(1) << active_q) - CNT_W'(1);
        // Half-LSB bias before the arithmetic shift rounds ties toward +inf.
        rnd_bias    = (active_q == '0) ? '0 : ((ACC_W+1)'(1) << (active_q - LW'(1)));
        rnd_sum     = $signed({acc_sum[ACC_W-1], acc_sum}) + rnd_bias;
        cfg_clamped = (cfg_log2_n > LW'(LOG2_N_MAX)) ? LW'(LOG2_N_MAX) : cfg_log2_n;

        frame_end   = in_valid && !clear && (count_q == last_cnt);
        boundary    = clear || frame_end || ((count_q == '0) && !in_valid);
        cfg_accept  = cfg_valid && !pending_q;

        acc_d       = acc_q;
        count_d     = count_q;
        out_data_d  = out_data_q;
        out_valid_d = frame_end;
        active_d    = active_q;
        pending_d   = pending_q;
        pend_val_d  = pend_val_q;

        if (frame_end) begin
            out_data_d = IN_W'(rnd_sum >>> active_q);
        end

        if (clear || frame_end) begin
            acc_d   = '0;
            count_d = '0;
        end else if (in_valid) begin
            acc_d   = acc_sum;
            count_d = count_q + CNT_W'(1);
        end

        // A request landing on a boundary bypasses the pending slot entirely.
        if (boundary) begin
            if (cfg_accept) begin
                active_d = cfg_clamped;
            end else if (pending_q) begin
                active_d = pend_val_q;
            end
            pending_d = 1'b0;
        end else if (cfg_accept) begin
            pending_d  = 1'b1;
            pend_val_d = cfg_clamped;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            count_q     <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            active_q    <= LW'(DEFAULT_LOG2_N);
            pending_q   <= 1'b0;
            pend_val_q  <= '0;
        end else begin
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_val_q  <= pend_val_d;
        end
    end

    assign cfg_ready    = !pending_q;
    assign out_data     = out_data_q;
    assign out_valid    = out_valid_q;
    assign active_log2n = active_q;

endmodule

// File: tb/tb_demod_boxcar_decimator.sv
// Bench for demod_boxcar_decimator: directed frame table, corner sequences and a randomized run
// checked cycle by cycle against a queue-based frame-averaging model.
module tb_demod_boxcar_decimator;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        clear;
    logic [3:0]  cfg_log2_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic [3:0]  active_log2n;

    demod_boxcar_decimator dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .clear        (clear),
        .cfg_log2_n   (cfg_log2_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .active_log2n (active_log2n)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state: samples of the open frame, exponent in use, pending request.
    longint      frame_q[$];
    int          m_active;
    bit          m_pend;
    int          m_pval;
    bit          m_ov;
    logic [31:0] m_od;

    typedef struct packed {
        int log2n;
        int n;
        int s0;
        int s1;
        int s2;
        int s3;
        int exp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        frame_q.delete();
        m_active = 4;
        m_pend   = 1'b0;
        m_pval   = 0;
        m_ov     = 1'b0;
        m_od     = '0;
    endtask

    task automatic cyc(input bit iv, input int d, input bit clr, input bit cv, input int cl);
        bit     bnd;
        bit     ok;
        int     clamped;
        longint s;
        in_valid   = iv;
        in_data    = d;
        clear      = clr;
        cfg_valid  = cv;
        cfg_log2_n = 4'(cl);
        bnd        = 1'b0;
        ok         = cv && !m_pend;
        clamped    = (cl > 10) ? 10 : cl;
        m_ov       = 1'b0;
        if (clr) begin
            frame_q.delete();
            bnd = 1'b1;
        end else if (iv) begin
            frame_q.push_back(longint'(d));
            if (frame_q.size() == (1 << m_active)) begin
                s = 0;
                foreach (frame_q[k]) s += frame_q[k];
                if (m_active > 0) s += (64'sd1 << (m_active - 1));
                m_od = 32'(s >>> m_active);
                m_ov = 1'b1;
                frame_q.delete();
                bnd = 1'b1;
            end
        end else if (frame_q.size() == 0) begin
            bnd = 1'b1;
        end
        if (bnd) begin
            if (ok) m_active = clamped;
            else if (m_pend) m_active = m_pval;
            m_pend = 1'b0;
        end else if (ok) begin
            m_pend = 1'b1;
            m_pval = clamped;
        end
        @(posedge clk);
        #1;
        chk("out_valid", out_valid, m_ov);
        chk("out_data", $signed(out_data), $signed(m_od));
        chk("active_log2n", active_log2n, m_active);
        chk("cfg_ready", cfg_ready, !m_pend);
    endtask

    initial begin
        int s[4];
        vec_t v;

        tbl[0] = '{log2n: 2, n: 4, s0: 10, s1: 20, s2: 30, s3: 40, exp: 25};
        tbl[1] = '{log2n: 1, n: 2, s0: -3, s1: -4, s2: 0,  s3: 0,  exp: -3};
        tbl[2] = '{log2n: 1, n: 2, s0: 3,  s1: 4,  s2: 0,  s3: 0,  exp: 4};
        tbl[3] = '{log2n: 1, n: 2, s0: -1, s1: 0,  s2: 0,  s3: 0,  exp: 0};
        tbl[4] = '{log2n: 2, n: 4, s0: -1, s1: -1, s2: -1, s3: -2, exp: -1};
        tbl[5] = '{log2n: 0, n: 1, s0: -9, s1: 0,  s2: 0,  s3: 0,  exp: -9};

        rst = 1'b1; in_valid = 0; in_data = 0; clear = 0; cfg_valid = 0; cfg_log2_n = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_data", out_data, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_active", active_log2n, 4);
        chk("rst_cfg_ready", cfg_ready, 1);
        rst = 1'b0;
        cyc(0, 0, 0, 0, 0);

        for (int i = 0; i < 6; i++) begin
            v = tbl[i];
            s[0] = v.s0; s[1] = v.s1; s[2] = v.s2; s[3] = v.s3;
            cyc(0, 0, 0, 1, v.log2n);
            chk("tbl_active", active_log2n, v.log2n);
            for (int k = 0; k < v.n; k++) cyc(1, s[k], 0, 0, 0);
            chk("tbl_valid", out_valid, 1);
            chk("tbl_data", $signed(out_data), v.exp);
            cyc(0, 0, 0, 0, 0);
        end

        // Out-of-range request clamps to the maximum frame length.
        cyc(0, 0, 0, 1, 15);
        chk("clamp_active", active_log2n, 10);
        for (int k = 0; k < 1024; k++) cyc(1, 32'h7FFFFFFF, 0, 0, 0);
        chk("max_valid", out_valid, 1);
        chk("max_data", out_data, 32'h7FFFFFFF);
        for (int k = 0; k < 1024; k++) cyc(1, int'(32'h80000000), 0, 0, 0);
        chk("min_valid", out_valid, 1);
        chk("min_data", out_data, 32'h80000000);

        cyc(0, 0, 0, 1, 0);
        cyc(1, 5, 0, 0, 0);
        chk("pass_5", $signed(out_data), 5);
        cyc(0, 0, 0, 0, 0);
        chk("pass_gap", out_valid, 0);
        cyc(1, -7, 0, 0, 0);
        chk("pass_m7", $signed(out_data), -7);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 9, 0, 0, 0);
        chk("pass_9", $signed(out_data), 9);

        cyc(0, 0, 0, 1, 2);
        cyc(1, 1, 0, 0, 0);
        cyc(1, 2, 0, 0, 0);
        cyc(0, 0, 0, 1, 1);
        chk("mid_ready_low", cfg_ready, 0);
        chk("mid_active_old", active_log2n, 2);
        cyc(1, 3, 0, 1, 1);
        cyc(1, 4, 0, 0, 0);
        chk("mid_avg4", $signed(out_data), 3);
        chk("mid_ready_high", cfg_ready, 1);
        chk("mid_active_new", active_log2n, 1);
        cyc(1, 6, 0, 0, 0);
        cyc(1, 7, 0, 0, 0);
        chk("mid_avg2", $signed(out_data), 7);

        cyc(0, 0, 0, 1, 2);
        cyc(1, 8, 0, 0, 0);
        cyc(1, 8, 0, 0, 0);
        cyc(1, 8, 0, 0, 0);
        cyc(1, 99, 1, 0, 0);
        chk("clr_no_pulse", out_valid, 0);
        for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0, 0);
        chk("clr_next_valid", out_valid, 1);
        chk("clr_next_data", $signed(out_data), 1);

        // Asynchronous reset between edges with a request pending and a frame half full.
        cyc(1, 50, 0, 0, 0);
        cyc(1, 60, 0, 1, 3);
        in_valid = 0; cfg_valid = 0; clear = 0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_data", out_data, 0);
        chk("arst_out_valid", out_valid, 0);
        chk("arst_active", active_log2n, 4);
        chk("arst_cfg_ready", cfg_ready, 1);
        model_reset();
        #1;
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) cyc(1, k, 0, 0, 0);
        chk("arst_frame_valid", out_valid, 1);
        chk("arst_frame_data", $signed(out_data), 9);

        for (int t = 0; t < 4000; t++) begin
            int cl;
            cl = ($urandom_range(0, 31) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
            cyc(($urandom_range(0, 3) != 0), int'($urandom()), ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 7) == 0), cl);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
